// File: rtl/coin_collector_vend_if.sv
// Coin acceptor, dispenser handshake and display bundle for coin_collector_vend.
// master = coin acceptor / dispenser side, slave = the collector itself.
interface coin_collector_vend_if #(
    parameter int SUM_W = 10
);
    logic [1:0]       coin;
    logic             cancel;
    logic             vend_ack;
    logic             done;
    logic             coin_reject;
    logic             refund_valid;
    logic [SUM_W-1:0] refund_amt;
    logic             change_valid;
    logic [SUM_W-1:0] change_amt;
    logic [6:0]       seg0;
    logic [6:0]       seg1;
    logic [6:0]       seg2;

    modport master (
        output coin, cancel, vend_ack,
        input  done, coin_reject, refund_valid, refund_amt,
        input  change_valid, change_amt, seg0, seg1, seg2
    );

    modport slave (
        input  coin, cancel, vend_ack,
        output done, coin_reject, refund_valid, refund_amt,
        output change_valid, change_amt, seg0, seg1, seg2
    );
endinterface

// File: rtl/coin_collector_vend.sv
// Coin collector: accumulates coins to PRICE, holds a vend request until acknowledged,
// refunds on cancel, drives a 3-digit 7-segment display. Define CHANGE_RETURN_EN for change return.
module coin_collector_vend #(
    parameter int PRICE = 100,
    parameter int VAL0  = 25,
    parameter int VAL1  = 50,
    parameter int VAL2  = 100,
    parameter int SUM_W = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    coin_collector_vend_if.slave  bus
);
    localparam int               DISP_W  = 10;
    localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
    localparam logic [DISP_W-1:0] PRICE_D = DISP_W'(PRICE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [SUM_W-1:0]    sum_r, sum_s;
    logic [DISP_W-1:0]   disp_r, disp_s;
    logic                done_r, done_s;
    logic                coin_reject_r, coin_reject_s;
    logic                refund_valid_r, refund_valid_s;
    logic [SUM_W-1:0]    refund_amt_r, refund_amt_s;
    logic                change_valid_r, change_valid_s;
    logic [SUM_W-1:0]    change_amt_r, change_amt_s;
    logic                coin_valid_s;
    logic [SUM_W-1:0]    sum_add_s;
    logic [11:0]         bcd_s;

    function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   return SUM_W'(VAL0);
            2'b01:   return SUM_W'(VAL1);
            2'b10:   return SUM_W'(VAL2);
            default: return {SUM_W{1'b0}};
        endcase
    endfunction

    // Shift-add-3 binary-to-BCD: {hundreds, tens, units}
    function automatic logic [11:0] to_bcd(input logic [DISP_W-1:0] bin);
        logic [21:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < DISP_W; i++) begin
            sh[13:10] = (sh[13:10] >= 4'd5) ? sh[13:10] + 4'd3 : sh[13:10];
            sh[17:14] = (sh[17:14] >= 4'd5) ? sh[17:14] + 4'd3 : sh[17:14];
            sh[21:18] = (sh[21:18] >= 4'd5) ? sh[21:18] + 4'd3 : sh[21:18];
            sh = sh << 1;
        end
        return sh[21:10];
    endfunction

    function automatic logic [6:0] to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign coin_valid_s = (bus.coin != 2'b11);
    assign sum_add_s    = sum_r + coin_value(bus.coin);

    // Next-state and registered-output decode
    always_comb begin
        state_s        = state_r;
        sum_s          = sum_r;
        disp_s         = disp_r;
        done_s         = done_r;
        coin_reject_s  = 1'b0;
        refund_valid_s = 1'b0;
        refund_amt_s   = {SUM_W{1'b0}};
        change_valid_s = 1'b0;
        change_amt_s   = {SUM_W{1'b0}};
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (bus.cancel) begin
                    // Cancel wins over a same-cycle coin; the coin is bounced, not refunded
                    coin_reject_s = coin_valid_s;
                    if (state_r == ST_COLLECT) begin
                        refund_valid_s = 1'b1;
                        refund_amt_s   = sum_r;
                        sum_s          = {SUM_W{1'b0}};
                        disp_s         = {DISP_W{1'b0}};
                        state_s        = ST_IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end else if (coin_valid_s) begin
                    sum_s = sum_add_s;
                    if (sum_add_s >= PRICE_S) begin
                        state_s = ST_VEND;
                        done_s  = 1'b1;
                        disp_s  = PRICE_D;
`ifdef CHANGE_RETURN_EN
                        change_valid_s = 1'b1;
                        change_amt_s   = sum_add_s - PRICE_S;
`else
                        change_valid_s = 1'b0;
                        change_amt_s   = {SUM_W{1'b0}};
`endif
                    end else begin
                        state_s = ST_COLLECT;
                        disp_s  = DISP_W'(sum_add_s);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_VEND: begin
                coin_reject_s = coin_valid_s;
                if (bus.vend_ack) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b0;
                    sum_s   = {SUM_W{1'b0}};
                    disp_s  = {DISP_W{1'b0}};
                end else begin
                    state_s = ST_VEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
                done_s  = 1'b0;
                sum_s   = {SUM_W{1'b0}};
                disp_s  = {DISP_W{1'b0}};
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            sum_r          <= {SUM_W{1'b0}};
            disp_r         <= {DISP_W{1'b0}};
            done_r         <= 1'b0;
            coin_reject_r  <= 1'b0;
            refund_valid_r <= 1'b0;
            refund_amt_r   <= {SUM_W{1'b0}};
            change_valid_r <= 1'b0;
            change_amt_r   <= {SUM_W{1'b0}};
        end else begin
            state_r        <= state_s;
            sum_r          <= sum_s;
            disp_r         <= disp_s;
            done_r         <= done_s;
            coin_reject_r  <= coin_reject_s;
            refund_valid_r <= refund_valid_s;
            refund_amt_r   <= refund_amt_s;
            change_valid_r <= change_valid_s;
            change_amt_r   <= change_amt_s;
        end
    end

    // Display decode straight from the registered amount
    always_comb begin
        bcd_s    = to_bcd(disp_r);
        bus.seg0 = to_seg(bcd_s[3:0]);
        bus.seg1 = to_seg(bcd_s[7:4]);
        bus.seg2 = to_seg(bcd_s[11:8]);
    end

    assign bus.done         = done_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.refund_valid = refund_valid_r;
    assign bus.refund_amt   = refund_amt_r;
    assign bus.change_valid = change_valid_r;
    assign bus.change_amt   = change_amt_r;
endmodule

// File: tb/tb_coin_collector_vend.sv
// Self-checking bench: directed scenarios plus randomized traffic on two instances
// (PRICE=100 and PRICE=150) against an amount-based reference model.
module tb_coin_collector_vend;
    localparam int SUM_W = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    coin_collector_vend_if #(.SUM_W(SUM_W)) bus_a ();
    coin_collector_vend_if #(.SUM_W(SUM_W)) bus_b ();

    coin_collector_vend #(.PRICE(100), .VAL0(25), .VAL1(50), .VAL2(100), .SUM_W(SUM_W)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave));
    coin_collector_vend #(.PRICE(150), .VAL0(25), .VAL1(50), .VAL2(100), .SUM_W(SUM_W)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: collected amount and whether a vend is outstanding
    int price [2] = '{100, 150};
    int m_amt [2];
    bit m_vend [2];
    bit e_done [2], e_rej [2], e_rv [2], e_cv [2];
    int e_ra [2], e_ca [2], e_disp [2];

    logic             o_done, o_rej, o_rv, o_cv;
    logic [SUM_W-1:0] o_ra, o_ca;
    logic [20:0]      o_segs;

    function automatic int coin_paise(input logic [1:0] c);
        return (c == 2'b00) ? 25 : (c == 2'b01) ? 50 : (c == 2'b10) ? 100 : 0;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tab[d];
    endfunction

    function automatic logic [20:0] segs_of(input int v);
        return {seg_of((v / 100) % 10), seg_of((v / 10) % 10), seg_of(v % 10)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_amt[k] = 0; m_vend[k] = 1'b0;
            e_done[k] = 1'b0; e_rej[k] = 1'b0; e_rv[k] = 1'b0; e_cv[k] = 1'b0;
            e_ra[k] = 0; e_ca[k] = 0; e_disp[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [1:0] c, input bit cn, input bit ack);
        bit valid;
        valid = (c != 2'b11);
        e_rej[k] = 1'b0; e_rv[k] = 1'b0; e_ra[k] = 0; e_cv[k] = 1'b0; e_ca[k] = 0;
        if (m_vend[k]) begin
            e_rej[k] = valid;
            if (ack) begin m_vend[k] = 1'b0; m_amt[k] = 0; end
        end else if (cn) begin
            e_rej[k] = valid;
            if (m_amt[k] > 0) begin e_rv[k] = 1'b1; e_ra[k] = m_amt[k]; m_amt[k] = 0; end
        end else if (valid) begin
            m_amt[k] += coin_paise(c);
            if (m_amt[k] >= price[k]) begin
                m_vend[k] = 1'b1;
`ifdef CHANGE_RETURN_EN
                e_cv[k] = 1'b1; e_ca[k] = m_amt[k] - price[k];
`endif
            end
        end
        e_done[k] = m_vend[k];
        e_disp[k] = m_vend[k] ? price[k] : m_amt[k];
    endtask

    task automatic set_idle();
        bus_a.coin = 2'b11; bus_a.cancel = 1'b0; bus_a.vend_ack = 1'b0;
        bus_b.coin = 2'b11; bus_b.cancel = 1'b0; bus_b.vend_ack = 1'b0;
    endtask

    // One clock edge with the given inputs on each instance; returns 1 time unit after the edge
    task automatic cycle(input logic [1:0] ca, input bit cna, input bit acka,
                         input logic [1:0] cb, input bit cnb, input bit ackb);
        @(negedge clock);
        bus_a.coin = ca; bus_a.cancel = cna; bus_a.vend_ack = acka;
        bus_b.coin = cb; bus_b.cancel = cnb; bus_b.vend_ack = ackb;
        model_step(0, ca, cna, acka);
        model_step(1, cb, cnb, ackb);
        @(posedge clock);
        #1;
        set_idle();
    endtask

    task automatic cyc_a(input logic [1:0] c, input bit cn, input bit ack);
        cycle(c, cn, ack, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic sample(input int k);
        if (k == 0) begin
            o_done = bus_a.done; o_rej = bus_a.coin_reject; o_rv = bus_a.refund_valid;
            o_ra = bus_a.refund_amt; o_cv = bus_a.change_valid; o_ca = bus_a.change_amt;
            o_segs = {bus_a.seg2, bus_a.seg1, bus_a.seg0};
        end else begin
            o_done = bus_b.done; o_rej = bus_b.coin_reject; o_rv = bus_b.refund_valid;
            o_ra = bus_b.refund_amt; o_cv = bus_b.change_valid; o_ca = bus_b.change_amt;
            o_segs = {bus_b.seg2, bus_b.seg1, bus_b.seg0};
        end
    endtask

    task automatic test_reset();
        set_idle();
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            sample(k);
            n_tests++;
            if ({o_done, o_rej, o_rv, o_cv, o_ra, o_ca} !== 24'd0) begin
                n_fail++; $display("FAIL reset_outputs inst%0d: got %h want 0", k, {o_done, o_rej, o_rv, o_cv, o_ra, o_ca});
            end
            n_tests++;
            if (o_segs !== {3{7'b1000000}}) begin
                n_fail++; $display("FAIL reset_segs inst%0d: got %b want 000", k, o_segs);
            end
        end
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic test_accumulate();
        for (int i = 1; i <= 4; i++) begin
            cyc_a(2'b00, 1'b0, 1'b0);
            sample(0);
            n_tests++;
            if (o_segs !== segs_of(25 * i)) begin
                n_fail++; $display("FAIL accum_segs step%0d: got %b want %b", i, o_segs, segs_of(25 * i));
            end
            n_tests++;
            if (o_done !== (i == 4)) begin
                n_fail++; $display("FAIL accum_done step%0d: got %b want %b", i, o_done, (i == 4));
            end
        end
        cyc_a(2'b11, 1'b0, 1'b1);
        sample(0);
        n_tests++;
        if (o_done !== 1'b0 || o_segs !== segs_of(0)) begin
            n_fail++; $display("FAIL accum_ack: got done=%b segs=%b want 0/000", o_done, o_segs);
        end
    endtask

    task automatic test_change();
        bit       exp_cv;
        int       exp_ca;
`ifdef CHANGE_RETURN_EN
        exp_cv = 1'b1; exp_ca = 25;
`else
        exp_cv = 1'b0; exp_ca = 0;
`endif
        cyc_a(2'b00, 1'b0, 1'b0);
        cyc_a(2'b10, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_done !== 1'b1 || o_segs !== segs_of(100)) begin
            n_fail++; $display("FAIL change_vend: got done=%b segs=%b want 1/100", o_done, o_segs);
        end
        n_tests++;
        if (o_cv !== exp_cv || o_ca !== SUM_W'(exp_ca)) begin
            n_fail++; $display("FAIL change_pulse: got %b/%0d want %b/%0d", o_cv, o_ca, exp_cv, exp_ca);
        end
        cyc_a(2'b11, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_cv !== 1'b0 || o_ca !== 10'd0) begin
            n_fail++; $display("FAIL change_clear: got %b/%0d want 0/0", o_cv, o_ca);
        end
        cyc_a(2'b11, 1'b0, 1'b1);
    endtask

    task automatic test_cancel();
        cyc_a(2'b01, 1'b0, 1'b0);
        cyc_a(2'b11, 1'b1, 1'b0);
        sample(0);
        n_tests++;
        if (o_rv !== 1'b1 || o_ra !== 10'd50 || o_segs !== segs_of(0) || o_done !== 1'b0) begin
            n_fail++; $display("FAIL cancel_refund: got rv=%b amt=%0d segs=%b want 1/50/000", o_rv, o_ra, o_segs);
        end
        cyc_a(2'b11, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_rv !== 1'b0 || o_ra !== 10'd0) begin
            n_fail++; $display("FAIL cancel_clear: got rv=%b amt=%0d want 0/0", o_rv, o_ra);
        end
        cyc_a(2'b01, 1'b0, 1'b0);
        cyc_a(2'b00, 1'b1, 1'b0);
        sample(0);
        n_tests++;
        if (o_rv !== 1'b1 || o_ra !== 10'd50 || o_rej !== 1'b1 || o_segs !== segs_of(0)) begin
            n_fail++; $display("FAIL cancel_coin: got rv=%b amt=%0d rej=%b want 1/50/1", o_rv, o_ra, o_rej);
        end
        cyc_a(2'b11, 1'b1, 1'b0);
        sample(0);
        n_tests++;
        if (o_rv !== 1'b0 || o_rej !== 1'b0) begin
            n_fail++; $display("FAIL cancel_idle: got rv=%b rej=%b want 0/0", o_rv, o_rej);
        end
    endtask

    task automatic test_vend_hold();
        cyc_a(2'b10, 1'b0, 1'b0);
        cyc_a(2'b01, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_rej !== 1'b1 || o_done !== 1'b1 || o_segs !== segs_of(100)) begin
            n_fail++; $display("FAIL vend_reject: got rej=%b done=%b segs=%b want 1/1/100", o_rej, o_done, o_segs);
        end
        cyc_a(2'b11, 1'b1, 1'b0);
        repeat (5) cyc_a(2'b11, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_done !== 1'b1 || o_rv !== 1'b0 || o_segs !== segs_of(100)) begin
            n_fail++; $display("FAIL vend_hold: got done=%b rv=%b want 1/0", o_done, o_rv);
        end
        cyc_a(2'b00, 1'b0, 1'b1);
        sample(0);
        n_tests++;
        if (o_rej !== 1'b1 || o_done !== 1'b0 || o_segs !== segs_of(0)) begin
            n_fail++; $display("FAIL vend_ack_coin: got rej=%b done=%b segs=%b want 1/0/000", o_rej, o_done, o_segs);
        end
        cyc_a(2'b11, 1'b0, 1'b1);
        cyc_a(2'b00, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_done !== 1'b0 || o_segs !== segs_of(25)) begin
            n_fail++; $display("FAIL ack_idle: got done=%b segs=%b want 0/025", o_done, o_segs);
        end
        cyc_a(2'b11, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        repeat (3) cyc_a(2'b00, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_segs !== segs_of(75)) begin
            n_fail++; $display("FAIL areset_pre: got %b want 075", o_segs);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        sample(0);
        n_tests++;
        if ({o_done, o_rej, o_rv, o_cv, o_ra, o_ca} !== 24'd0 || o_segs !== segs_of(0)) begin
            n_fail++; $display("FAIL areset_now: got %h segs=%b want 0/000", {o_done, o_rej, o_rv, o_cv, o_ra, o_ca}, o_segs);
        end
        @(negedge clock) reset = 1'b1;
        cyc_a(2'b11, 1'b0, 1'b0);
        sample(0);
        n_tests++;
        if (o_rv !== 1'b0 || o_segs !== segs_of(0)) begin
            n_fail++; $display("FAIL areset_after: got rv=%b segs=%b want 0/000", o_rv, o_segs);
        end
    endtask

    task automatic test_price150();
        bit exp_cv;
`ifdef CHANGE_RETURN_EN
        exp_cv = 1'b1;
`else
        exp_cv = 1'b0;
`endif
        cycle(2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        sample(1);
        n_tests++;
        if (o_done !== 1'b0 || o_segs !== segs_of(100)) begin
            n_fail++; $display("FAIL p150_first: got done=%b segs=%b want 0/100", o_done, o_segs);
        end
        cycle(2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        sample(1);
        n_tests++;
        if (o_done !== 1'b1 || o_segs !== segs_of(150) || o_cv !== exp_cv || o_ca !== 10'd0) begin
            n_fail++; $display("FAIL p150_vend: got done=%b segs=%b cv=%b ca=%0d want 1/150/%b/0", o_done, o_segs, o_cv, o_ca, exp_cv);
        end
        cycle(2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [1:0] ca, cb;
        bit         na, nb, ka, kb;
        for (int i = 0; i < 500; i++) begin
            ca = 2'($urandom_range(0, 3)); cb = 2'($urandom_range(0, 3));
            na = ($urandom_range(0, 7) == 0); nb = ($urandom_range(0, 7) == 0);
            ka = ($urandom_range(0, 3) == 0); kb = ($urandom_range(0, 3) == 0);
            cycle(ca, na, ka, cb, nb, kb);
            for (int k = 0; k < 2; k++) begin
                sample(k);
                n_tests++;
                if ({o_done, o_rej, o_rv, o_cv} !== {e_done[k], e_rej[k], e_rv[k], e_cv[k]}) begin
                    n_fail++; $display("FAIL rand_flags inst%0d cyc%0d: got %b want %b", k, i,
                        {o_done, o_rej, o_rv, o_cv}, {e_done[k], e_rej[k], e_rv[k], e_cv[k]});
                end
                n_tests++;
                if (o_ra !== SUM_W'(e_ra[k]) || o_ca !== SUM_W'(e_ca[k])) begin
                    n_fail++; $display("FAIL rand_amts inst%0d cyc%0d: got %0d/%0d want %0d/%0d", k, i, o_ra, o_ca, e_ra[k], e_ca[k]);
                end
                n_tests++;
                if (o_segs !== segs_of(e_disp[k])) begin
                    n_fail++; $display("FAIL rand_segs inst%0d cyc%0d: got %b want %b", k, i, o_segs, segs_of(e_disp[k]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_change();
        test_cancel();
        test_vend_hold();
        test_async_reset();
        test_price150();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
